// File: rtl/sd_block_responder.sv
// rtl/sd_block_responder.sv - four-channel SD block responder bridging 512-byte blocks to a byte-wide backing store
module sd_block_responder #(
  parameter logic [31:0] MAX_LBA    = 32'h0000_FFFF,
  parameter int          GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] sd_lba [4],
  input  logic [3:0]  sd_rd,
  input  logic [3:0]  sd_wr,
  output logic [3:0]  sd_ack,
  output logic [13:0] sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din [4],
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARB     = 4'd1;
  localparam logic [3:0] S_RD_REQ  = 4'd2;
  localparam logic [3:0] S_RD_PUSH = 4'd3;
  localparam logic [3:0] S_WR_ADDR = 4'd4;
  localparam logic [3:0] S_WR_WAIT = 4'd5;
  localparam logic [3:0] S_WR_REQ  = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_GAP     = 4'd8;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  logic [3:0]  state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] lba_q, lba_d;
  logic        oob_q, oob_d;
  logic [8:0]  off_q, off_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;

  logic [3:0]  req;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic        xfer;

  // Round-robin search starts one past the last served channel.
  always_comb begin
    req   = sd_rd | sd_wr;
    pick  = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = last_q + 2'(i + 1);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    lba_d   = lba_q;
    oob_d   = oob_q;
    off_d   = off_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (found) begin
          ch_d    = pick;
          last_d  = pick;
          lba_d   = sd_lba[pick];
          oob_d   = (sd_lba[pick] > MAX_LBA);
          off_d   = 9'd0;
          state_d = sd_wr[pick] ? S_WR_ADDR : S_RD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (oob_q || mem_ready) begin
          data_d  = oob_q ? 8'h00 : mem_dout;
          state_d = S_RD_PUSH;
        end
      end
      S_RD_PUSH: begin
        off_d   = off_q + 9'd1;
        state_d = (off_q == 9'd511) ? S_DONE : S_RD_REQ;
      end
      S_WR_ADDR: begin
        cnt_d   = 16'd0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd1) begin
          data_d  = sd_buff_din[ch_q];
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (oob_q || mem_ready) begin
          off_d   = off_q + 9'd1;
          state_d = (off_q == 9'd511) ? S_DONE : S_WR_ADDR;
        end
      end
      S_DONE: begin
        cnt_d   = 16'd0;
        off_d   = 9'd0;
        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Channel 0 is served first after reset because the pointer starts at 3.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= 2'd0;
      last_q  <= 2'd3;
      lba_q   <= 32'd0;
      oob_q   <= 1'b0;
      off_q   <= 9'd0;
      data_q  <= 8'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      oob_q   <= oob_d;
      off_q   <= off_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign xfer = (state_q == S_RD_REQ) || (state_q == S_RD_PUSH) || (state_q == S_WR_ADDR) ||
                (state_q == S_WR_WAIT) || (state_q == S_WR_REQ);

  // Outputs are gated by state so idle and reset both present all zeros.
  assign sd_ack       = xfer ? (4'b0001 << ch_q) : 4'b0000;
  assign sd_buff_addr = xfer ? {5'b0, off_q} : 14'd0;
  assign sd_buff_wr   = (state_q == S_RD_PUSH);
  assign sd_buff_dout = sd_buff_wr ? data_q : 8'h00;
  assign mem_rd       = (state_q == S_RD_REQ) && !oob_q;
  assign mem_wr       = (state_q == S_WR_REQ) && !oob_q;
  assign mem_addr     = (mem_rd || mem_wr) ? {lba_q[22:0], off_q} : 32'd0;
  assign mem_din      = mem_wr ? data_q : 8'h00;

endmodule

// File: tb/tb_sd_block_responder.sv
// tb/tb_sd_block_responder.sv - directed self-checking bench for sd_block_responder
module tb_sd_block_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] sd_lba [4];
  logic [3:0]  sd_rd, sd_wr, sd_ack;
  logic [13:0] sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din [4];
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  din_reg = 8'h00;
  logic [7:0]  cyc = 8'h00;
  logic        bp;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  sd_block_responder #(.MAX_LBA(32'h0000_FFFF), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ready(mem_ready)
  );

  // Initiator returns a registered copy of the buffer address scrambled with 0x5A.
  always @(posedge clk) begin
    din_reg <= sd_buff_addr[7:0] ^ 8'h5A;
    cyc     <= cyc + 8'd1;
  end
  assign sd_buff_din[0] = din_reg;
  assign sd_buff_din[1] = din_reg;
  assign sd_buff_din[2] = din_reg;
  assign sd_buff_din[3] = din_reg;
  assign mem_dout  = mem_addr[7:0];
  assign mem_ready = bp ? (cyc[1:0] == 2'd3) : 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_a"}, {sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout}, 64'd0);
    check({tag, "_m"}, {mem_rd, mem_wr, mem_addr, mem_din}, 64'd0);
  endtask

  task automatic run_block(input string tag, input int ch, input logic [31:0] lba,
                           input bit is_wr, input bit oob);
    int t, eo, nstr, nmem, nerr, maxa;
    bit seen;
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    seen = 0; eo = 0; nstr = 0; nmem = 0; nerr = 0; maxa = 0;
    for (t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (sd_ack != 4'd0) seen = 1;
    end
    check({tag, "_ack"}, sd_ack, oh);
    if (!seen) return;
    t = 0;
    while (sd_ack != 4'd0 && t < 20000) begin
      if (sd_ack != oh) nerr++;
      if (mem_rd && mem_wr) nerr++;
      if (oob && (mem_rd || mem_wr)) nerr++;
      if (!is_wr) begin
        if (sd_buff_wr) begin
          if (sd_buff_addr != 14'(eo) || sd_buff_dout != (oob ? 8'h00 : 8'(eo))) nerr++;
          eo++; nstr++;
        end
        if (mem_rd && mem_ready) begin
          if (mem_addr != {lba[22:0], 9'(eo)}) nerr++;
          nmem++;
        end
        if (mem_wr) nerr++;
      end else begin
        if (int'(sd_buff_addr) > maxa) maxa = int'(sd_buff_addr);
        if (mem_wr && mem_ready) begin
          if (mem_addr != {lba[22:0], 9'(eo)} || mem_din != (8'(eo) ^ 8'h5A)) nerr++;
          eo++; nmem++;
        end
        if (mem_rd || sd_buff_wr) nerr++;
      end
      @(negedge clk);
      t++;
    end
    check({tag, "_end"}, t < 20000, 1);
    if (!is_wr) check({tag, "_strobes"}, nstr, 512);
    else        check({tag, "_maxaddr"}, maxa, 511);
    check({tag, "_memops"}, nmem, oob ? 0 : 512);
    check({tag, "_errs"}, nerr, 0);
  endtask

  initial begin
    int t;
    bit hit;
    reset_n = 1'b0; sd_rd = 4'd0; sd_wr = 4'd0; bp = 1'b0;
    for (int i = 0; i < 4; i++) sd_lba[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("idle");

    sd_lba[1] = 32'd5; sd_rd = 4'b0010;
    run_block("rd", 1, 32'd5, 0, 0);
    sd_rd = 4'd0;
    repeat (8) @(negedge clk);
    check_quiet("post_rd");

    sd_lba[2] = 32'd2; sd_wr = 4'b0100;
    run_block("wr", 2, 32'd2, 1, 0);
    sd_wr = 4'd0;
    repeat (8) @(negedge clk);

    sd_lba[0] = 32'd0; sd_rd = 4'b0001;
    for (int b = 0; b < 3; b++) begin
      run_block($sformatf("multi%0d", b), 0, 32'(b), 0, 0);
      sd_lba[0] = 32'(b + 1);
    end
    sd_rd = 4'd0;
    repeat (8) @(negedge clk);
    check("multi_no_repeat", sd_ack, 4'd0);

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) sd_lba[i] = 32'd7;
    sd_rd = 4'b1011;
    run_block("arb0", 0, 32'd7, 0, 0);
    run_block("arb1", 1, 32'd7, 0, 0);
    run_block("arb3", 3, 32'd7, 0, 0);
    run_block("arb0b", 0, 32'd7, 0, 0);
    sd_rd = 4'd0;
    repeat (8) @(negedge clk);

    bp = 1'b1;
    sd_lba[1] = 32'h0001_0000; sd_rd = 4'b0010;
    run_block("oob_rd", 1, 32'h0001_0000, 0, 1);
    sd_rd = 4'd0;
    repeat (8) @(negedge clk);
    sd_lba[2] = 32'd3; sd_rd = 4'b0100;
    run_block("bp_rd", 2, 32'd3, 0, 0);
    sd_rd = 4'd0;
    repeat (8) @(negedge clk);
    sd_lba[3] = 32'hFFFF_FFFF; sd_wr = 4'b1000;
    run_block("oob_wr", 3, 32'hFFFF_FFFF, 1, 1);
    sd_wr = 4'd0;
    bp = 1'b0;
    repeat (8) @(negedge clk);

    sd_lba[2] = 32'd1; sd_wr = 4'b0100;
    hit = 0;
    for (t = 0; t < 5000 && !hit; t++) begin
      @(negedge clk);
      if (mem_wr && mem_ready && mem_addr == 32'h0000_0264) hit = 1;
    end
    check("rst_byte100_seen", hit, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    @(negedge clk);
    check_quiet("rst_hold");
    sd_wr = 4'd0; sd_rd = 4'b1001;
    sd_lba[0] = 32'd9; sd_lba[3] = 32'd4;
    reset_n = 1'b1;
    run_block("rst_prio", 0, 32'd9, 0, 0);
    sd_rd = 4'd0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_block_responder.md
SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

Interface
REQ-001 SHALL have parameter MAX_LBA, default 32'h0000_FFFF: highest valid block number.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: idle cycles after each ack fall before the next request is sampled.
REQ-003 SHALL have clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 SHALL have reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have sd_lba[4], input, 32 each: block number per channel.
REQ-006 SHALL have sd_rd, input, 4: per-channel read request level.
REQ-007 SHALL have sd_wr, input, 4: per-channel write request level.
REQ-008 SHALL have sd_ack, output, 4: per-channel transfer-active flag.
REQ-009 SHALL have sd_buff_addr, output, 14: byte offset in block; only bits [8:0] are used, [13:9] = 0.
REQ-010 SHALL have sd_buff_dout, output, 8: read data to the initiator.
REQ-011 SHALL have sd_buff_wr, output, 1: one-cycle strobe qualifying sd_buff_dout and sd_buff_addr.
REQ-012 SHALL have sd_buff_din[4], input, 8 each: write data from the initiator.
REQ-013 SHALL have mem_addr, output, 32: byte address = {sd_lba[22:0], offset[8:0]}.
REQ-014 SHALL have mem_rd and mem_wr, output, 1 each: backing-store request levels, held until accepted.
REQ-015 SHALL have mem_din, output, 8: write data to the backing store.
REQ-016 SHALL have mem_dout, input, 8: read data from the backing store, valid in the cycle mem_ready=1.
REQ-017 SHALL have mem_ready, input, 1: accepts the current mem_rd or mem_wr.

Function
REQ-018 SHALL implement FSM states IDLE, ARB, RD_REQ, RD_PUSH, WR_ADDR, WR_WAIT, WR_REQ, DONE, GAP.
REQ-019 IDLE: with no request pending, SHALL stay in IDLE with all outputs at reset values.
REQ-020 IDLE: if any sd_rd|sd_wr bit is set, SHALL go to ARB.
REQ-021 ARB SHALL pick a channel round-robin, starting at (last served + 1) mod 4.
REQ-022 ARB SHALL latch the channel number, sd_lba, and direction, then assert sd_ack[ch] in the next cycle.
REQ-023 If both sd_wr[ch] and sd_rd[ch] are set, the write SHALL be served.
REQ-024 The latched LBA SHALL be used for the whole block; lba changes during ack SHALL be ignored.
REQ-025 Read, per byte: RD_REQ SHALL hold mem_rd=1 until mem_ready.
REQ-026 Read, per byte: RD_PUSH SHALL drive sd_buff_dout=mem_dout, pulse sd_buff_wr for 1 cycle, then increment the offset.
REQ-027 Write, per byte: WR_ADDR SHALL present sd_buff_addr; WR_WAIT SHALL wait 2 cycles.
REQ-028 Write, per byte: sd_buff_din[ch] SHALL be sampled exactly 2 cycles after the address appears.
REQ-029 Write, per byte: WR_REQ SHALL hold mem_wr=1 with mem_din until mem_ready, then increment the offset.
REQ-030 Offset SHALL be 9 bits, 0..511; after byte 511 the FSM SHALL go to DONE, with no wrap into a second block.
REQ-031 sd_ack[ch] SHALL stay high from the first cycle after ARB through the last byte.
REQ-032 DONE SHALL drop sd_ack to 0 and clear sd_buff_addr to 0.
REQ-033 GAP SHALL count GAP_CYCLES cycles, then return to IDLE so the initiator can advance lba or drop its request.
REQ-034 If latched LBA > MAX_LBA: reads SHALL return 0x00 for all 512 bytes with no mem_rd.
REQ-035 If latched LBA > MAX_LBA: writes SHALL run the full address sequence with no mem_wr.
REQ-036 At most one sd_ack bit SHALL be set at any time.
REQ-037 Requests arriving on other channels during a transfer SHALL wait; none SHALL be lost while their level stays high.
REQ-038 A request that drops mid-transfer SHALL NOT abort the block; the 512-byte transfer SHALL complete.
REQ-039 mem_rd and mem_wr SHALL never be high together.

Reset
REQ-040 When reset_n=0 at a clock edge, the next state SHALL be IDLE.
REQ-041 During reset: sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0.
REQ-042 During reset: mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0.
REQ-043 During reset: the round-robin pointer SHALL be set so channel 0 is served first.
REQ-044 Reset mid-transfer SHALL take effect on the next edge; the partial block is abandoned with no further mem or buff strobes.

Verification
REQ-045 Read: sd_rd[1]=1, lba=5, mem_ready always 1, memory byte = addr[7:0] -> sd_ack[1] high; 512 sd_buff_wr strobes; data = offset[7:0]; mem_addr 0xA00..0xBFF.
REQ-046 Write: sd_wr[2]=1, lba=2, initiator returns din = registered (addr ^ 0x5A) -> mem writes at 0x400..0x5FF, each value = offset[7:0] ^ 0x5A.
REQ-047 Multi-block: initiator holds sd_rd[0] and increments lba 0->1->2 after each ack fall -> three distinct acks at lba 0, 1, 2; no block repeated.
REQ-048 Arbitration: sd_rd = 4'b1011 held -> serve order 0, 1, 3, 0; sd_ack never has 2 bits set.
REQ-049 Range/backpressure: lba = MAX_LBA+1 read -> 512 zero bytes, no mem_rd; mem_ready low 3 of 4 cycles -> data still correct.
REQ-050 Reset: reset_n=0 at byte 100 of a write -> next cycle all outputs 0; after release with sd_rd[3]=1, channel 0 has priority if it requests.
